// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences PF_CCC power-up and lock from the board reference clock: holds the
//   PLL powered down, waits for lock with timeout/retry, qualifies lock as stable,
//   then releases the downstream fabric reset. In RUN, a filtered lock loss
//   re-asserts fabric reset and re-runs the sequence.
// Ports
//   CLK             reference clock (same source as CCC REF_CLK)
//   RST_N           asynchronous active-low reset
//   ENABLE          level; 0 forces IDLE (PLL down, fabric in reset)
//   RESTART         pulse; restart from PWRDN, clears FAULT and retry count
//   PLL_LOCK        PLL lock, asynchronous to CLK
//   PLL_POWERDOWN_N to CCC, 0 = powered down
//   FAB_RST_N       downstream active-low reset, high only in RUN
//   READY / FAULT   state flags for RUN / FAULT
//   STATE           current state encoding
//   RETRY_COUNT     lock timeouts in current sequence, saturating at 15
//   LOSS_COUNT      lock-loss events since reset, saturating at 255
module pll_lock_supervisor #(
   parameter int unsigned PWRDN_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned LOSS_FILTER   = 4,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ENABLE,
   input  logic       RESTART,
   input  logic       PLL_LOCK,
   output logic       PLL_POWERDOWN_N,
   output logic       FAB_RST_N,
   output logic       READY,
   output logic       FAULT,
   output logic [2:0] STATE,
   output logic [3:0] RETRY_COUNT,
   output logic [7:0] LOSS_COUNT
);

   localparam int unsigned T_MAX_A = (PWRDN_CYCLES > LOCK_TIMEOUT) ? PWRDN_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned T_MAX_B = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
   localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned TW      = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PWRDN     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      retry_q, retry_d;
   logic [7:0]      loss_q, loss_d;
   logic            sync1_q, lock_s;
   logic            pd_n_q, fab_rst_n_q, ready_q, fault_q;

   // Two-flop synchronizer for the asynchronous lock input
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_q <= PLL_LOCK;
         lock_s  <= sync1_q;
      end
   end

   // State, shared timer, counters and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pd_n_q      <= 1'b0;
         fab_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pd_n_q      <= state_d inside {ST_WAIT_LOCK, ST_STABLE, ST_RUN};
         fab_rst_n_q <= (state_d == ST_RUN);
         ready_q     <= (state_d == ST_RUN);
         fault_q     <= (state_d == ST_FAULT);
      end
   end

   // Next-state logic; the timer doubles as the RUN unlock filter counter
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      if (!ENABLE) begin
         state_d = ST_IDLE;
         timer_d = '0;
         retry_d = '0;
      end else if (RESTART) begin
         state_d = ST_PWRDN;
         timer_d = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_PWRDN;
               timer_d = '0;
            end
            ST_PWRDN: begin
               if (timer_q == TW'(PWRDN_CYCLES - 1)) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = ST_STABLE;
                  timer_d = '0;
               end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                  timer_d = '0;
                  if (32'(retry_q) < MAX_RETRIES) begin
                     retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                     state_d = ST_PWRDN;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  timer_d = '0;
               end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                  state_d = ST_RUN;
                  timer_d = '0;
               end
            end
            ST_RUN: begin
               if (lock_s) begin
                  timer_d = '0;
               end else if (timer_q == TW'(LOSS_FILTER - 1)) begin
                  loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                  retry_d = '0;
                  state_d = ST_PWRDN;
                  timer_d = '0;
               end
            end
            ST_FAULT: begin
               timer_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   assign PLL_POWERDOWN_N = pd_n_q;
   assign FAB_RST_N       = fab_rst_n_q;
   assign READY           = ready_q;
   assign FAULT           = fault_q;
   assign STATE           = state_q;
   assign RETRY_COUNT     = retry_q;
   assign LOSS_COUNT      = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed sequences plus a random phase,
// every cycle compared against a rule-level reference model.
module tb_pll_lock_supervisor;

   localparam int unsigned PWRDN  = 16;
   localparam int unsigned LOCKTO = 200;
   localparam int unsigned STABLE = 64;
   localparam int unsigned LOSSF  = 4;
   localparam int unsigned MAXR   = 3;

   localparam int SIG_PD     = 0;
   localparam int SIG_FAB    = 1;
   localparam int SIG_READY  = 2;
   localparam int SIG_FAULT  = 3;
   localparam int SIG_STABLE = 4;

   logic       clk = 1'b0;
   logic       rst_n, enable, restart, pll_lock;
   logic       pd_n, fab_rst_n, ready, fault;
   logic [2:0] state;
   logic [3:0] retry_count;
   logic [7:0] loss_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: state number, cycles spent, counters, lock history
   int   m_state, m_n, m_retry, m_loss;
   logic h1, h2;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .PWRDN_CYCLES (PWRDN),
      .LOCK_TIMEOUT (LOCKTO),
      .STABLE_CYCLES(STABLE),
      .LOSS_FILTER  (LOSSF),
      .MAX_RETRIES  (MAXR)
   ) dut (
      .CLK            (clk),
      .RST_N          (rst_n),
      .ENABLE         (enable),
      .RESTART        (restart),
      .PLL_LOCK       (pll_lock),
      .PLL_POWERDOWN_N(pd_n),
      .FAB_RST_N      (fab_rst_n),
      .READY          (ready),
      .FAULT          (fault),
      .STATE          (state),
      .RETRY_COUNT    (retry_count),
      .LOSS_COUNT     (loss_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_n     = 0;
      m_retry = 0;
      m_loss  = 0;
      h1      = 1'b0;
      h2      = 1'b0;
   endtask

   // One clock edge worth of the behavioural rules
   task automatic model_step();
      logic ls;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ls = h2;
      h2 = h1;
      h1 = pll_lock;
      if (!enable) begin
         m_state = 0; m_n = 0; m_retry = 0;
      end else if (restart) begin
         m_state = 1; m_n = 0; m_retry = 0;
      end else begin
         case (m_state)
            0: begin m_state = 1; m_n = 0; end
            1: begin
               m_n++;
               if (m_n >= PWRDN) begin m_state = 2; m_n = 0; end
            end
            2: begin
               if (ls) begin
                  m_state = 3; m_n = 0;
               end else begin
                  m_n++;
                  if (m_n >= LOCKTO) begin
                     m_n = 0;
                     if (m_retry < MAXR) begin
                        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                        m_state = 1;
                     end else begin
                        m_state = 5;
                     end
                  end
               end
            end
            3: begin
               if (!ls) m_n = 0;
               else begin
                  m_n++;
                  if (m_n >= STABLE) begin m_state = 4; m_n = 0; end
               end
            end
            4: begin
               if (ls) m_n = 0;
               else begin
                  m_n++;
                  if (m_n >= LOSSF) begin
                     m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                     m_retry = 0;
                     m_state = 1;
                     m_n     = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      chk("m_state", 32'(state), 32'(m_state));
      chk("m_pd_n",  32'(pd_n),  32'((m_state == 2) || (m_state == 3) || (m_state == 4)));
      chk("m_fab",   32'(fab_rst_n), 32'(m_state == 4));
      chk("m_ready", 32'(ready), 32'(m_state == 4));
      chk("m_fault", 32'(fault), 32'(m_state == 5));
      chk("m_retry", 32'(retry_count), 32'(m_retry));
      chk("m_loss",  32'(loss_count),  32'(m_loss));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic cur(input int which);
      case (which)
         SIG_PD:     return pd_n;
         SIG_FAB:    return fab_rst_n;
         SIG_READY:  return ready;
         SIG_FAULT:  return fault;
         default:    return (state == 3'd3);
      endcase
   endfunction

   // Advance until the selected output equals val; n is edges consumed (budget on expiry)
   task automatic wait_sig(input int which, input logic val, input int budget, output int n);
      n = 0;
      while (n < budget && cur(which) !== val) begin
         cycle();
         n++;
      end
   endtask

   initial begin
      #5_000_000;
      n_fail++;
      $display("FAIL watchdog got=%0d exp=0", 1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int n, d, g, rises;
      logic prev, saw;
      rst_n = 1'b0; enable = 1'b0; restart = 1'b0; pll_lock = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("rst_state", 32'(state), 32'd0);
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();

      // T1: power-up and lock
      enable = 1'b1;
      wait_sig(SIG_PD, 1'b1, 100, n);
      chk("t1_pd_delay", 32'(n), 32'(PWRDN + 1));
      d = $urandom_range(20, 150);
      repeat (d) cycle();
      pll_lock = 1'b1;
      wait_sig(SIG_FAB, 1'b1, 500, n);
      chk("t1_fab_delay", 32'(n), 32'(STABLE + 3));
      chk("t1_state", 32'(state), 32'd4);
      chk("t1_ready", 32'(ready), 32'd1);
      chk("t1_retry", 32'(retry_count), 32'd0);
      chk("t1_loss", 32'(loss_count), 32'd0);

      // T3: short glitch ignored, long drop counted and re-sequenced
      g = $urandom_range(1, LOSSF - 1);
      pll_lock = 1'b0;
      repeat (g) cycle();
      pll_lock = 1'b1;
      repeat (10) cycle();
      chk("t3_glitch_state", 32'(state), 32'd4);
      chk("t3_glitch_loss", 32'(loss_count), 32'd0);
      pll_lock = 1'b0;
      wait_sig(SIG_FAB, 1'b0, 50, n);
      chk("t3_loss_delay", 32'(n), 32'(LOSSF + 2));
      chk("t3_loss_count", 32'(loss_count), 32'd1);
      chk("t3_state_pwrdn", 32'(state), 32'd1);
      repeat (4) cycle();
      pll_lock = 1'b1;
      wait_sig(SIG_READY, 1'b1, 400, n);
      chk("t3_rerun", 32'(state), 32'd4);

      // T4: chattering lock in STABLE never reaches RUN
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      chk("t4_restart_state", 32'(state), 32'd1);
      chk("t4_restart_fab", 32'(fab_rst_n), 32'd0);
      saw = 1'b0;
      for (int i = 0; i < 600; i++) begin
         pll_lock = ((i % 50) == 49) ? 1'b0 : 1'b1;
         cycle();
         if (fab_rst_n !== 1'b0) saw = 1'b1;
      end
      pll_lock = 1'b1;
      chk("t4_no_run", 32'(saw), 32'd0);
      chk("t4_state", 32'(state), 32'd3);
      chk("t4_loss", 32'(loss_count), 32'd1);

      // T2: no lock -> retries then FAULT, cleared by RESTART
      pll_lock = 1'b0;
      restart  = 1'b1;
      cycle();
      restart = 1'b0;
      n = 1;
      rises = 0;
      prev = pd_n;
      while (n < 2000 && fault !== 1'b1) begin
         cycle();
         n++;
         if (prev === 1'b0 && pd_n === 1'b1) rises++;
         prev = pd_n;
      end
      chk("t2_fault_delay", 32'(n), 32'((MAXR + 1) * (PWRDN + LOCKTO) + 1));
      chk("t2_attempts", 32'(rises), 32'(MAXR + 1));
      chk("t2_retry", 32'(retry_count), 32'(MAXR));
      chk("t2_pd", 32'(pd_n), 32'd0);
      repeat (5) cycle();
      chk("t2_fault_held", 32'(state), 32'd5);
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      chk("t2_clr_fault", 32'(fault), 32'd0);
      chk("t2_clr_state", 32'(state), 32'd1);
      chk("t2_clr_retry", 32'(retry_count), 32'd0);

      // T5: ENABLE=0 mid-WAIT_LOCK and mid-RUN, async reset mid-STABLE
      repeat (PWRDN + 5) cycle();
      chk("t5_in_wait", 32'(state), 32'd2);
      enable = 1'b0;
      cycle();
      chk("t5_wait_off_state", 32'(state), 32'd0);
      chk("t5_wait_off_pd", 32'(pd_n), 32'd0);
      chk("t5_wait_off_fab", 32'(fab_rst_n), 32'd0);
      enable = 1'b1;
      pll_lock = 1'b1;
      wait_sig(SIG_READY, 1'b1, 400, n);
      chk("t5_run", 32'(state), 32'd4);
      repeat (7) cycle();
      enable = 1'b0;
      cycle();
      chk("t5_run_off_state", 32'(state), 32'd0);
      chk("t5_run_off_fab", 32'(fab_rst_n), 32'd0);
      chk("t5_run_off_loss", 32'(loss_count), 32'd1);
      enable = 1'b1;
      wait_sig(SIG_STABLE, 1'b1, 100, n);
      repeat (10) cycle();
      chk("t5_in_stable", 32'(state), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_arst_state", 32'(state), 32'd0);
      chk("t5_arst_pd", 32'(pd_n), 32'd0);
      chk("t5_arst_fab", 32'(fab_rst_n), 32'd0);
      chk("t5_arst_ready", 32'(ready), 32'd0);
      chk("t5_arst_fault", 32'(fault), 32'd0);
      chk("t5_arst_loss", 32'(loss_count), 32'd0);
      model_reset();
      cycle();
      rst_n = 1'b1;

      // T6: loss counter saturation
      pll_lock = 1'b1;
      for (int k = 0; k < 260; k++) begin
         wait_sig(SIG_READY, 1'b1, 300, n);
         chk("t6_ready", 32'(ready), 32'd1);
         pll_lock = 1'b0;
         repeat (LOSSF + 2) cycle();
         pll_lock = 1'b1;
      end
      chk("t6_loss_sat", 32'(loss_count), 32'd255);

      // Random phase against the model
      for (int i = 0; i < 4000; i++) begin
         enable  = ($urandom_range(0, 199) != 0);
         restart = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 119) == 0) pll_lock = ~pll_lock;
         cycle();
      end
      enable  = 1'b0;
      restart = 1'b0;
      cycle();
      chk("end_idle", 32'(state), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
